// File: rtl/pc_ctrl.sv
// Program counter and branch resolution: run sequencing, branch-target table,
// retired-instruction counter and sticky overflow flag.
//
// state | meaning
// IDLE  | waiting for start; pc, count and overflow hold their last values
// RUN   | executing; one instruction retires per non-stalled cycle
// DONE  | one-cycle pulse after halt retires, then back to IDLE
module pc_ctrl #(
  parameter int PC_W      = 10,
  parameter int LUT_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [PC_W-1:0]      start_addr,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 jump_en,
  input  logic                 branch_en,
  input  logic                 branch_flag,
  input  logic                 alu_overflow,
  input  logic [LUT_IDX_W-1:0] branch_idx,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]      lut_wdata,
  output logic [PC_W-1:0]      pc,
  output logic                 running,
  output logic                 done,
  output logic [15:0]          instr_count,
  output logic                 ovf_sticky
);

  localparam int LUT_N = 1 << LUT_IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [PC_W-1:0] lut_q [LUT_N];
  logic [PC_W-1:0] lut_d [LUT_N];
  logic [PC_W-1:0] target;
  logic            retire;

  // Read uses the registered table, so a same-cycle write is seen next cycle.
  assign target = lut_q[branch_idx];

  always_comb begin
    lut_d = lut_q;
    if (lut_we) lut_d[lut_waddr] = lut_wdata;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    retire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = start_addr;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        if (!stall) begin
          retire = 1'b1;
          if (halt) begin
            state_d = DONE;
          end else if (jump_en || (branch_en && branch_flag)) begin
            pc_d = target;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (retire) begin
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      if (alu_overflow)      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < LUT_N; i++) lut_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      lut_q   <= lut_d;
    end
  end

  assign pc          = pc_q;
  assign running     = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign instr_count = cnt_q;
  assign ovf_sticky  = ovf_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl with hand-computed expected values.
module tb_pc_ctrl;
  localparam int PC_W = 10;
  localparam int LUT_IDX_W = 4;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 start;
  logic [PC_W-1:0]      start_addr;
  logic                 stall, halt, jump_en, branch_en, branch_flag, alu_overflow;
  logic [LUT_IDX_W-1:0] branch_idx;
  logic                 lut_we;
  logic [LUT_IDX_W-1:0] lut_waddr;
  logic [PC_W-1:0]      lut_wdata;
  logic [PC_W-1:0]      pc;
  logic                 running, done, ovf_sticky;
  logic [15:0]          instr_count;

  int errors = 0;
  int checks = 0;

  pc_ctrl #(.PC_W(PC_W), .LUT_IDX_W(LUT_IDX_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .stall(stall), .halt(halt), .jump_en(jump_en), .branch_en(branch_en),
    .branch_flag(branch_flag), .alu_overflow(alu_overflow), .branch_idx(branch_idx),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .pc(pc), .running(running), .done(done), .instr_count(instr_count),
    .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    start = 0; stall = 0; halt = 0; jump_en = 0; branch_en = 0;
    branch_flag = 0; alu_overflow = 0; branch_idx = '0; lut_we = 0;
    lut_waddr = '0; lut_wdata = '0;
  endtask

  // Advance one edge and settle; inputs are then re-driven between edges.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lut_write(input logic [LUT_IDX_W-1:0] a, input logic [PC_W-1:0] d);
    lut_we = 1; lut_waddr = a; lut_wdata = d;
    step();
    clr();
  endtask

  task automatic do_start(input logic [PC_W-1:0] a);
    start = 1; start_addr = a;
    step();
    clr();
  endtask

  task automatic finish_run();
    halt = 1;
    step();
    clr();
    step();
  endtask

  initial begin
    clr();
    start_addr = '0;
    reset_n = 0;
    step(); step();
    chk("rst_pc", pc, 0);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_ovf", ovf_sticky, 0);
    reset_n = 1;
    step();

    // Reset mid-run clears pc, state and table
    lut_write(4'd3, 10'h155);
    do_start(10'h05A);
    chk("mid_run_pc", pc, 10'h05A);
    chk("mid_run_running", running, 1);
    alu_overflow = 1;
    step();
    clr();
    reset_n = 0;
    #2;
    chk("async_rst_pc", pc, 0);
    chk("async_rst_running", running, 0);
    chk("async_rst_count", instr_count, 0);
    chk("async_rst_ovf", ovf_sticky, 0);
    step();
    reset_n = 1;
    step();
    do_start(10'h100);
    jump_en = 1; branch_idx = 4'd3;
    step();
    clr();
    chk("lut3_after_rst", pc, 0);
    finish_run();

    // Straight-line run with wrap
    do_start(10'h3FE);
    chk("seq_pc0", pc, 10'h3FE);
    step(); chk("seq_pc1", pc, 10'h3FF);
    step(); chk("seq_pc2", pc, 10'h000);
    step(); chk("seq_pc3", pc, 10'h001);
    step(); chk("seq_pc4", pc, 10'h002);
    chk("seq_count", instr_count, 4);
    finish_run();

    // Branch resolution
    lut_write(4'd2, 10'h120);
    do_start(10'h010);
    branch_en = 1; branch_idx = 4'd2; branch_flag = 1;
    step();
    chk("br_taken", pc, 10'h120);
    branch_flag = 0;
    step();
    chk("br_not_taken", pc, 10'h121);
    branch_en = 0; jump_en = 1;
    step();
    clr();
    chk("jump_flag0", pc, 10'h120);

    // Stall beats halt and jump, and blocks overflow capture
    stall = 1; halt = 1; jump_en = 1; branch_idx = 4'd2; alu_overflow = 1;
    step();
    chk("stall_pc", pc, 10'h120);
    chk("stall_count", instr_count, 3);
    chk("stall_ovf", ovf_sticky, 0);
    chk("stall_running", running, 1);
    stall = 0; alu_overflow = 0;
    branch_idx = 4'd3;
    step();
    clr();
    chk("halt_pc", pc, 10'h120);
    chk("halt_done", done, 1);
    chk("halt_running", running, 0);
    chk("halt_count", instr_count, 4);
    start = 1; start_addr = 10'h300;
    step();
    clr();
    chk("done_start_ignored_run", running, 0);
    chk("done_pulse_end", done, 0);
    chk("idle_pc_hold", pc, 10'h120);
    step();
    chk("idle_stays", running, 0);
    chk("idle_count_hold", instr_count, 4);

    // Table write/read hazard
    lut_write(4'd5, 10'h010);
    do_start(10'h050);
    lut_we = 1; lut_waddr = 4'd5; lut_wdata = 10'h200;
    jump_en = 1; branch_idx = 4'd5;
    step();
    lut_we = 0;
    chk("hazard_old", pc, 10'h010);
    step();
    clr();
    chk("hazard_new", pc, 10'h200);
    finish_run();
    chk("prev_count", instr_count, 3);

    // Run bookkeeping
    do_start(10'h000);
    chk("bk_count_clr0", instr_count, 0);
    step();
    alu_overflow = 1; start = 1; start_addr = 10'h3A0;
    step();
    clr();
    chk("bk_start_in_run", pc, 10'h002);
    step();
    chk("bk_pc", pc, 10'h003);
    chk("bk_count3", instr_count, 3);
    chk("bk_ovf", ovf_sticky, 1);
    halt = 1;
    step();
    clr();
    chk("bk_count4", instr_count, 4);
    chk("bk_done", done, 1);
    step();
    chk("bk_done_one", done, 0);
    chk("bk_ovf_hold", ovf_sticky, 1);
    chk("bk_count_hold", instr_count, 4);
    do_start(10'h077);
    chk("bk_new_count", instr_count, 0);
    chk("bk_new_ovf", ovf_sticky, 0);
    chk("bk_new_pc", pc, 10'h077);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
